// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data access.
// One transaction at a time, data has strict priority, and a taken branch (flush)
// silently discards the pending or in-flight fetch. Stall outputs feed the hazard unit.
module mem_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Fetch port (IF stage)
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic [DW-1:0]     if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              flush,
  // Data port (MEM stage)
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DW/8-1:0]   d_be,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic [DW-1:0]     d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  // Memory bus
  output logic              bus_req,
  output logic              bus_we,
  output logic [DW/8-1:0]   bus_be,
  output logic [AW-1:0]     bus_addr,
  output logic [DW-1:0]     bus_wdata,
  input  logic              bus_ack,
  input  logic [DW-1:0]     bus_rdata
);

  localparam int unsigned BW = DW / 8;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e          state_q, state_d;

  // Transaction fields, only loaded on the IDLE->BUSY edge
  logic            bus_we_q, bus_we_d;
  logic [BW-1:0]   bus_be_q, bus_be_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;

  // owner: 1 = fetch, 0 = data. drop: the current fetch was killed by a flush.
  logic            owner_q, owner_d;
  logic            drop_q, drop_d;

  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_valid_q, if_valid_d;
  logic            d_valid_q, d_valid_d;

  // Next-state logic: grant, bus completion capture and flush bookkeeping
  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_req) begin
          bus_we_d    = d_we;
          bus_be_d    = d_be;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
          owner_d     = 1'b0;
          state_d     = StBusy;
        end else if (if_req && !flush) begin
          bus_we_d    = 1'b0;
          bus_be_d    = '1;
          bus_addr_d  = if_addr;
          owner_d     = 1'b1;
          drop_d      = 1'b0;
          state_d     = StBusy;
        end
      end

      StBusy: begin
        // A flush on the ack cycle still kills the fetch
        if (owner_q && flush) begin
          drop_d = 1'b1;
        end
        if (bus_ack) begin
          state_d = StDone;
          if (owner_q) begin
            if_rdata_d = bus_rdata;
            if_valid_d = ~drop_q & ~flush;
          end else begin
            d_valid_d = 1'b1;
            // Stores leave the previous load data in place
            if (!bus_we_q) begin
              d_rdata_d = bus_rdata;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      owner_q     <= 1'b0;
      drop_q      <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  // Outputs: bus_req decodes the state register so reset drops it asynchronously
  always_comb begin
    bus_req   = (state_q == StBusy);
    bus_we    = bus_we_q;
    bus_be    = bus_be_q;
    bus_addr  = bus_addr_q;
    bus_wdata = bus_wdata_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    // A branch in the completion cycle also kills the fetch result
    if_valid  = if_valid_q & ~flush;
    d_valid   = d_valid_q;
    if_stall  = if_req & ~if_valid;
    d_stall   = d_req & ~d_valid;
  end

endmodule
